// File: rtl/mpp20_beacon_pkg.sv
// Shared definitions for the MPP20 beacon serial transmitter.
package mpp20_beacon_pkg;

   localparam logic [7:0]  PREAMBLE_DEFAULT = 8'h7E;
   localparam int unsigned FRAME_BITS       = 33;
   localparam int unsigned WORD_W           = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_PARITY,
      ST_GAP
   } state_e;

endpackage

// File: rtl/mpp20_beacon_tx_bit_tick.sv
// Bit-period divider: counts 0..BIT_DIV-1 and ticks on the last count.
module mpp20_bit_tick #(
   parameter int unsigned BIT_DIV = 4
) (
   input  logic clk,
   input  logic clr,
   output logic tick
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == 8'(BIT_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mpp20_beacon_tx.sv
// Serialises 24-bit beacon words as preamble + data + even parity + idle gap.
module mpp20_beacon_tx
   import mpp20_beacon_pkg::*;
#(
   parameter int unsigned BIT_DIV  = 4,
   parameter int unsigned GAP_BITS = 2,
   parameter logic [7:0]  PREAMBLE = PREAMBLE_DEFAULT
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              enable,
   input  logic [WORD_W-1:0] BeaconData_in,
   input  logic              data_valid,
   output logic              ready,
   output logic              tx_bit,
   output logic              tx_active,
   output logic              frame_done
);

   localparam int unsigned LAST_BIT = FRAME_BITS + GAP_BITS - 1;

   state_e                  state_q, state_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [5:0]              bit_cnt_q, bit_cnt_d;
   logic                    accept;
   logic                    tick;

   mpp20_bit_tick #(
      .BIT_DIV(BIT_DIV)
   ) u_bit_tick (
      .clk (Clk),
      .clr (accept || Rst),
      .tick(tick)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      frame_done = 1'b0;
      tx_bit     = 1'b0;
      ready      = (state_q == ST_IDLE) && enable;
      accept     = ready && data_valid;
      tx_active  = (state_q != ST_IDLE);

      // bit_cnt keeps running through the gap so one compare marks the frame end
      if (state_q != ST_IDLE && tick) begin
         shift_d   = shift_q << 1;
         bit_cnt_d = bit_cnt_q + 6'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shift_d   = {PREAMBLE, BeaconData_in, ^BeaconData_in};
               bit_cnt_d = '0;
               state_d   = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            tx_bit = shift_q[FRAME_BITS-1];
            if (tick && bit_cnt_q == 6'd7) state_d = ST_DATA;
         end
         ST_DATA: begin
            tx_bit = shift_q[FRAME_BITS-1];
            if (tick && bit_cnt_q == 6'(FRAME_BITS - 2)) state_d = ST_PARITY;
         end
         ST_PARITY: begin
            tx_bit = shift_q[FRAME_BITS-1];
            if (tick) begin
               if (GAP_BITS == 0) begin
                  state_d    = ST_IDLE;
                  frame_done = 1'b1;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (tick && bit_cnt_q == 6'(LAST_BIT)) begin
               state_d    = ST_IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: tb/tb_mpp20_beacon_tx.sv
// Directed bench for mpp20_beacon_tx: default timing instance plus a BIT_DIV=1, GAP_BITS=0 instance.
module tb_mpp20_beacon_tx;

   logic        clk = 1'b0;
   logic        rst, en, dv;
   logic [23:0] din;
   logic        rdy_a, bit_a, act_a, done_a;
   logic        rdy_b, bit_b, act_b, done_b;
   int          errors = 0;
   int          checks = 0;
   logic [299:0] cb_a, ca_a, cd_a, cr_a, cb_b, ca_b, cd_b;

   always #5 clk = ~clk;

   mpp20_beacon_tx #(.BIT_DIV(4), .GAP_BITS(2), .PREAMBLE(8'h7E)) dut_a (
      .Clk(clk), .Rst(rst), .enable(en), .BeaconData_in(din), .data_valid(dv),
      .ready(rdy_a), .tx_bit(bit_a), .tx_active(act_a), .frame_done(done_a)
   );

   mpp20_beacon_tx #(.BIT_DIV(1), .GAP_BITS(0), .PREAMBLE(8'h7E)) dut_b (
      .Clk(clk), .Rst(rst), .enable(en), .BeaconData_in(din), .data_valid(dv),
      .ready(rdy_b), .tx_bit(bit_b), .tx_active(act_b), .frame_done(done_b)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // expected tx_bit waveform: 33-bit sequence MSB first, div cycles per bit, from index start
   function automatic logic [299:0] wave_bits(input logic [32:0] seq, input int unsigned div,
                                              input int unsigned start);
      logic [299:0] v;
      v = '0;
      for (int unsigned i = 0; i < 33 * div; i++) v[start + i] = seq[32 - i / div];
      return v;
   endfunction

   function automatic logic [299:0] span(input int unsigned s, input int unsigned n);
      logic [299:0] v;
      v = '0;
      for (int unsigned i = 0; i < n; i++) v[s + i] = 1'b1;
      return v;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic start_word(input logic [23:0] w);
      din = w;
      dv  = 1'b1;
      next_cycle();
      dv  = 1'b0;
   endtask

   task automatic capture(input int unsigned n, input int unsigned ev_at, input logic [23:0] ev_din,
                          input logic ev_en, input logic ev_dv);
      cb_a = '0; ca_a = '0; cd_a = '0; cr_a = '0; cb_b = '0; ca_b = '0; cd_b = '0;
      for (int unsigned k = 0; k < n; k++) begin
         if (k == ev_at) begin
            din = ev_din;
            en  = ev_en;
            dv  = ev_dv;
         end
         #1;
         cb_a[k] = bit_a; ca_a[k] = act_a; cd_a[k] = done_a; cr_a[k] = rdy_a;
         cb_b[k] = bit_b; ca_b[k] = act_b; cd_b[k] = done_b;
         next_cycle();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; dv = 1'b1; din = 24'hFFFFFF;
      repeat (3) next_cycle();
      rst = 1'b0; dv = 1'b0;
      #1;
      checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", act_a); end
      checks++; if (bit_a !== 1'b0) begin errors++; $display("FAIL reset_txbit: got %b expected 0", bit_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
      checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready_en1: got %b expected 1", rdy_a); end
      checks++; if (act_b !== 1'b0 || rdy_b !== 1'b1) begin
         errors++; $display("FAIL reset_b: got act=%b rdy=%b expected act=0 rdy=1", act_b, rdy_b);
      end
      en = 1'b0;
      #1;
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_ready_en0: got %b expected 0", rdy_a); end
      en = 1'b1;
      next_cycle();
      #1;
      checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL reset_dv_ignored: got act=%b expected 0", act_a); end
   endtask

   task automatic test_frame();
      start_word(24'hA5C3F0);
      capture(140, 9999, 24'hA5C3F0, 1'b1, 1'b0);
      checks++; if (cb_a !== wave_bits({8'h7E, 24'hA5C3F0, 1'b0}, 4, 0)) begin
         errors++; $display("FAIL frame_bits: got %h expected %h", cb_a, wave_bits({8'h7E, 24'hA5C3F0, 1'b0}, 4, 0));
      end
      checks++; if (ca_a !== span(0, 140)) begin
         errors++; $display("FAIL frame_active: got %h expected %h", ca_a, span(0, 140));
      end
      checks++; if (cd_a !== span(139, 1)) begin
         errors++; $display("FAIL frame_done: got %h expected %h", cd_a, span(139, 1));
      end
      #1;
      checks++; if (act_a !== 1'b0 || bit_a !== 1'b0 || rdy_a !== 1'b1) begin
         errors++; $display("FAIL frame_after: got act=%b bit=%b rdy=%b expected 0 0 1", act_a, bit_a, rdy_a);
      end
   endtask

   task automatic test_parity_one();
      start_word(24'h000001);
      capture(140, 9999, 24'h000001, 1'b1, 1'b0);
      checks++; if (cb_a !== wave_bits({8'h7E, 24'h000001, 1'b1}, 4, 0)) begin
         errors++; $display("FAIL parity_bits: got %h expected %h", cb_a, wave_bits({8'h7E, 24'h000001, 1'b1}, 4, 0));
      end
      checks++; if (cb_a[127:124] !== 4'hF) begin
         errors++; $display("FAIL data_bit0_cycles_125_128: got %h expected f", cb_a[127:124]);
      end
      checks++; if (cb_a[131:128] !== 4'hF) begin
         errors++; $display("FAIL parity_bit_one: got %h expected f", cb_a[131:128]);
      end
      checks++; if (cb_a[123:120] !== 4'h0) begin
         errors++; $display("FAIL data_bit1_zero: got %h expected 0", cb_a[123:120]);
      end
   endtask

   task automatic test_back_to_back();
      logic [299:0] eb, ea, ed;
      din = 24'h123456;
      dv  = 1'b1;
      next_cycle();
      capture(281, 140, 24'hFEDCBA, 1'b1, 1'b1);
      eb = wave_bits({8'h7E, 24'h123456, 1'b1}, 4, 0) | wave_bits({8'h7E, 24'hFEDCBA, 1'b1}, 4, 141);
      ea = span(0, 140) | span(141, 140);
      ed = span(139, 1) | span(280, 1);
      checks++; if (cb_a !== eb) begin errors++; $display("FAIL b2b_bits: got %h expected %h", cb_a, eb); end
      checks++; if (ca_a !== ea) begin errors++; $display("FAIL b2b_active: got %h expected %h", ca_a, ea); end
      checks++; if (cd_a !== ed) begin errors++; $display("FAIL b2b_done: got %h expected %h", cd_a, ed); end
      checks++; if (cr_a !== span(140, 1)) begin
         errors++; $display("FAIL b2b_ready: got %h expected %h", cr_a, span(140, 1));
      end
      dv = 1'b0;
      #1;
      checks++; if (act_a !== 1'b0 || rdy_a !== 1'b1) begin
         errors++; $display("FAIL b2b_end: got act=%b rdy=%b expected 0 1", act_a, rdy_a);
      end
   endtask

   task automatic test_reset_mid_frame();
      start_word(24'h0F0F0F);
      capture(49, 9999, 24'h0F0F0F, 1'b1, 1'b0);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      #1;
      checks++; if (act_a !== 1'b0 || bit_a !== 1'b0 || done_a !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs: got act=%b bit=%b done=%b expected 0 0 0", act_a, bit_a, done_a);
      end
      checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", rdy_a); end
      start_word(24'hA5C3F0);
      capture(140, 9999, 24'hA5C3F0, 1'b1, 1'b0);
      checks++; if (cb_a !== wave_bits({8'h7E, 24'hA5C3F0, 1'b0}, 4, 0)) begin
         errors++; $display("FAIL midreset_next_bits: got %h expected %h", cb_a, wave_bits({8'h7E, 24'hA5C3F0, 1'b0}, 4, 0));
      end
      checks++; if (cd_a !== span(139, 1)) begin
         errors++; $display("FAIL midreset_next_done: got %h expected %h", cd_a, span(139, 1));
      end
   endtask

   task automatic test_enable_drop();
      start_word(24'h3C3C3C);
      capture(140, 9, 24'h3C3C3C, 1'b0, 1'b1);
      checks++; if (cb_a !== wave_bits({8'h7E, 24'h3C3C3C, 1'b0}, 4, 0)) begin
         errors++; $display("FAIL endrop_bits: got %h expected %h", cb_a, wave_bits({8'h7E, 24'h3C3C3C, 1'b0}, 4, 0));
      end
      checks++; if (cd_a !== span(139, 1)) begin
         errors++; $display("FAIL endrop_done: got %h expected %h", cd_a, span(139, 1));
      end
      capture(20, 9999, 24'h3C3C3C, 1'b0, 1'b1);
      checks++; if (cr_a !== '0) begin errors++; $display("FAIL endrop_ready_low: got %h expected 0", cr_a); end
      checks++; if (ca_a !== '0) begin errors++; $display("FAIL endrop_dv_ignored: got %h expected 0", ca_a); end
      en = 1'b1;
      #1;
      checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL endrop_ready_back: got %b expected 1", rdy_a); end
      next_cycle();
      dv = 1'b0;
      #1;
      checks++; if (act_a !== 1'b1 || bit_a !== 1'b0) begin
         errors++; $display("FAIL endrop_accept: got act=%b bit=%b expected 1 0", act_a, bit_a);
      end
   endtask

   task automatic test_bitdiv1();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; en = 1'b1; dv = 1'b0;
      start_word(24'hC00001);
      capture(34, 9999, 24'hC00001, 1'b1, 1'b0);
      checks++; if (cb_b !== wave_bits({8'h7E, 24'hC00001, 1'b1}, 1, 0)) begin
         errors++; $display("FAIL div1_bits: got %h expected %h", cb_b, wave_bits({8'h7E, 24'hC00001, 1'b1}, 1, 0));
      end
      checks++; if (ca_b !== span(0, 33)) begin
         errors++; $display("FAIL div1_active: got %h expected %h", ca_b, span(0, 33));
      end
      checks++; if (cd_b !== span(32, 1)) begin
         errors++; $display("FAIL div1_done: got %h expected %h", cd_b, span(32, 1));
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; dv = 1'b0; din = '0;
      test_reset();
      test_frame();
      test_parity_one();
      test_back_to_back();
      test_reset_mid_frame();
      test_enable_drop();
      test_bitdiv1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
